// File: rtl/game_session_scheduler_pkg.sv
// Shared definitions for the arcade session scheduler: state encodings,
// default score width and the selection-width helper.
package game_pkg;

    localparam int DEFAULT_PW = 8;

    typedef enum logic [2:0] {
        ST_MENU    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUNNING = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    // Width of the menu selection index; never below one bit.
    function automatic int sel_w(input int num_games);
        return (num_games > 1) ? $clog2(num_games) : 1;
    endfunction

endpackage

// File: rtl/game_session_scheduler_button_edge.sv
// Rising-edge detector for one debounced button level. The previous-value
// register resets high so a button held through reset gives no edge.
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/game_session_scheduler.sv
// Arcade session controller: menu, launch, grant, result hold and abort for
// NUM_GAMES shared cores. Define MENU_AUTOCYCLE_EN for attract-mode menu cycling.
//
// state   | meaning
// MENU    | choose a game, menu_active high
// LAUNCH  | one-cycle start pulse to the selected core
// RUNNING | selected core owns buttons and display
// RESULT  | hold the result screen, then back to MENU
// ABORT   | one-cycle clear pulse to the selected core
module game_session_scheduler
    import game_pkg::*;
#(
    parameter int NUM_GAMES     = 4,
    parameter int PW            = DEFAULT_PW,
    parameter int RESULT_CYCLES = 150000000,
    parameter int IDLE_CYCLES   = 500000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              btn_select,
    input  logic                              btn_confirm,
    input  logic                              btn_quit,
    input  logic [NUM_GAMES-1:0]              game_finished,
    input  logic [NUM_GAMES*PW-1:0]           game_points,
    output logic [NUM_GAMES-1:0]              game_start,
    output logic [NUM_GAMES-1:0]              game_clear,
    output logic [NUM_GAMES-1:0]              game_active,
    output logic [sel_w(NUM_GAMES)-1:0]       selected,
    output logic                              menu_active,
    output logic [PW-1:0]                     last_points,
    output logic [PW-1:0]                     high_score,
    output logic                              new_record,
    output logic [2:0]                        state
);

    localparam int SEL_W = sel_w(NUM_GAMES);
    localparam int RC_W  = $clog2(RESULT_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESULT_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_GAMES - 1);

    logic sel_rise, conf_rise, quit_rise;

    button_edge u_sel_edge  (.clock(clock), .reset(reset), .level_i(btn_select),  .rise_o(sel_rise));
    button_edge u_conf_edge (.clock(clock), .reset(reset), .level_i(btn_confirm), .rise_o(conf_rise));
    button_edge u_quit_edge (.clock(clock), .reset(reset), .level_i(btn_quit),    .rise_o(quit_rise));

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d, sel_inc;
    logic [PW-1:0]     last_q, last_d;
    logic              newrec_q, newrec_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [PW-1:0]     score_q [NUM_GAMES];
    logic              score_we;
    logic              fin_sel;
    logic [PW-1:0]     pts_sel, hs_sel;
    logic [NUM_GAMES-1:0] sel_onehot;

`ifdef MENU_AUTOCYCLE_EN
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_hit;
    assign idle_hit = (idle_q == IDLE_LAST);
`endif

    always_comb begin
        fin_sel = 1'b0;
        pts_sel = '0;
        hs_sel  = '0;
        for (int i = 0; i < NUM_GAMES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                fin_sel = game_finished[i];
                pts_sel = game_points[i*PW +: PW];
                hs_sel  = score_q[i];
            end
        end
    end

    assign sel_inc    = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    assign sel_onehot = NUM_GAMES'(1) << sel_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        newrec_d    = newrec_q;
        rcnt_d      = rcnt_q;
        score_we    = 1'b0;
        game_start  = '0;
        game_clear  = '0;
        game_active = '0;
`ifdef MENU_AUTOCYCLE_EN
        idle_d      = '0;
`endif
        case (state_q)
            ST_MENU: begin
`ifdef MENU_AUTOCYCLE_EN
                if (!(sel_rise || conf_rise || quit_rise || idle_hit)) begin
                    idle_d = idle_q + 1'b1;
                end
`endif
                if (conf_rise) begin
                    state_d = ST_LAUNCH;
                end else if (sel_rise) begin
                    sel_d = sel_inc;
`ifdef MENU_AUTOCYCLE_EN
                end else if (idle_hit) begin
                    sel_d = sel_inc;
`endif
                end
            end
            ST_LAUNCH: begin
                game_start  = sel_onehot;
                game_active = sel_onehot;
                state_d     = ST_RUNNING;
            end
            ST_RUNNING: begin
                game_active = sel_onehot;
                // A finish outranks a quit arriving in the same cycle.
                if (fin_sel) begin
                    last_d = pts_sel;
                    if (pts_sel > hs_sel) begin
                        score_we = 1'b1;
                        newrec_d = 1'b1;
                    end
                    rcnt_d  = '0;
                    state_d = ST_RESULT;
                end else if (quit_rise) begin
                    state_d = ST_ABORT;
                end
            end
            ST_RESULT: begin
                game_active = sel_onehot;
                rcnt_d      = rcnt_q + 1'b1;
                if ((rcnt_q == RC_LAST) || conf_rise) begin
                    newrec_d = 1'b0;
                    state_d  = ST_MENU;
                end
            end
            ST_ABORT: begin
                game_clear = sel_onehot;
                state_d    = ST_MENU;
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_MENU;
            sel_q    <= '0;
            last_q   <= '0;
            newrec_q <= 1'b0;
            rcnt_q   <= '0;
            for (int i = 0; i < NUM_GAMES; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            newrec_q <= newrec_d;
            rcnt_q   <= rcnt_d;
            for (int i = 0; i < NUM_GAMES; i++) begin
                if (score_we && (sel_q == SEL_W'(i))) begin
                    score_q[i] <= pts_sel;
                end
            end
        end
    end

`ifdef MENU_AUTOCYCLE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign selected    = sel_q;
    assign menu_active = (state_q == ST_MENU);
    assign last_points = last_q;
    assign high_score  = hs_sel;
    assign new_record  = newrec_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_session_scheduler.sv
// Self-checking bench for game_session_scheduler with NUM_GAMES=3,
// RESULT_CYCLES=8, IDLE_CYCLES=16; MENU_AUTOCYCLE_EN is honoured if defined.
module tb_game_session_scheduler;

    localparam int NG = 3;
    localparam int RC = 8;
    localparam int IC = 16;
    localparam logic [2:0] S_MENU = 3'd0, S_LAUNCH = 3'd1, S_RUNNING = 3'd2,
                           S_RESULT = 3'd3, S_ABORT = 3'd4;

    logic        clock = 1'b0;
    logic        reset;
    logic        btn_select, btn_confirm, btn_quit;
    logic [2:0]  game_finished;
    logic [23:0] game_points;
    logic [2:0]  game_start, game_clear, game_active;
    logic [1:0]  selected;
    logic        menu_active;
    logic [7:0]  last_points, high_score;
    logic        new_record;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    game_session_scheduler #(
        .NUM_GAMES(NG), .PW(8), .RESULT_CYCLES(RC), .IDLE_CYCLES(IC)
    ) dut (
        .clock(clock), .reset(reset),
        .btn_select(btn_select), .btn_confirm(btn_confirm), .btn_quit(btn_quit),
        .game_finished(game_finished), .game_points(game_points),
        .game_start(game_start), .game_clear(game_clear), .game_active(game_active),
        .selected(selected), .menu_active(menu_active),
        .last_points(last_points), .high_score(high_score),
        .new_record(new_record), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: session rules applied once per clock.
    logic [2:0] m_state;
    logic [1:0] m_sel;
    logic [7:0] m_hs [NG];
    logic [7:0] m_last;
    logic       m_nr;
    int         m_cnt;
    int         m_idle;
    logic       m_ps, m_pc, m_pq;
    logic       m_se, m_ce, m_qe, m_fin;
    logic [7:0] m_pts;

    assign m_se  = btn_select  & ~m_ps;
    assign m_ce  = btn_confirm & ~m_pc;
    assign m_qe  = btn_quit    & ~m_pq;
    assign m_fin = game_finished[m_sel];
    assign m_pts = game_points[m_sel*8 +: 8];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state <= S_MENU;
            m_sel   <= 2'd0;
            m_last  <= 8'd0;
            m_nr    <= 1'b0;
            m_cnt   <= 0;
            m_idle  <= 0;
            m_ps    <= 1'b1;
            m_pc    <= 1'b1;
            m_pq    <= 1'b1;
            for (int i = 0; i < NG; i++) m_hs[i] <= 8'd0;
        end else begin
            m_ps   <= btn_select;
            m_pc   <= btn_confirm;
            m_pq   <= btn_quit;
            m_idle <= 0;
            case (m_state)
                S_MENU: begin
`ifdef MENU_AUTOCYCLE_EN
                    if (!(m_se || m_ce || m_qe || m_idle == IC - 1)) m_idle <= m_idle + 1;
`endif
                    if (m_ce) m_state <= S_LAUNCH;
                    else if (m_se) m_sel <= 2'((m_sel + 1) % NG);
`ifdef MENU_AUTOCYCLE_EN
                    else if (m_idle == IC - 1) m_sel <= 2'((m_sel + 1) % NG);
`endif
                end
                S_LAUNCH: m_state <= S_RUNNING;
                S_RUNNING: begin
                    if (m_fin) begin
                        m_last <= m_pts;
                        if (m_pts > m_hs[m_sel]) begin
                            m_hs[m_sel] <= m_pts;
                            m_nr <= 1'b1;
                        end
                        m_cnt   <= 0;
                        m_state <= S_RESULT;
                    end else if (m_qe) begin
                        m_state <= S_ABORT;
                    end
                end
                S_RESULT: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == RC - 1 || m_ce) begin
                        m_nr    <= 1'b0;
                        m_state <= S_MENU;
                    end
                end
                default: m_state <= S_MENU;
            endcase
        end
    end

    logic [2:0] e_start, e_clear, e_active;
    assign e_start  = (m_state == S_LAUNCH) ? (3'b001 << m_sel) : 3'b000;
    assign e_clear  = (m_state == S_ABORT)  ? (3'b001 << m_sel) : 3'b000;
    assign e_active = (m_state == S_LAUNCH || m_state == S_RUNNING || m_state == S_RESULT)
                      ? (3'b001 << m_sel) : 3'b000;

    always @(negedge clock) begin
        chk("m.state",       32'(state),       32'(m_state));
        chk("m.selected",    32'(selected),    32'(m_sel));
        chk("m.menu_active", 32'(menu_active), 32'(m_state == S_MENU));
        chk("m.game_start",  32'(game_start),  32'(e_start));
        chk("m.game_clear",  32'(game_clear),  32'(e_clear));
        chk("m.game_active", 32'(game_active), 32'(e_active));
        chk("m.last_points", 32'(last_points), 32'(m_last));
        chk("m.high_score",  32'(high_score),  32'(m_hs[m_sel]));
        chk("m.new_record",  32'(new_record),  32'(m_nr));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_select();
        btn_select = 1'b1; tick(1);
        btn_select = 1'b0; tick(1);
    endtask

    task automatic launch();
        btn_confirm = 1'b1; tick(1);
        btn_confirm = 1'b0; tick(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".state"},       32'(state),       32'd0);
        chk({tag, ".selected"},    32'(selected),    32'd0);
        chk({tag, ".menu_active"}, 32'(menu_active), 32'd1);
        chk({tag, ".start"},       32'(game_start),  32'd0);
        chk({tag, ".clear"},       32'(game_clear),  32'd0);
        chk({tag, ".active"},      32'(game_active), 32'd0);
        chk({tag, ".last"},        32'(last_points), 32'd0);
        chk({tag, ".high"},        32'(high_score),  32'd0);
        chk({tag, ".newrec"},      32'(new_record),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wrap_exp [4];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd0; wrap_exp[3] = 2'd1;

        reset = 1'b1;
        btn_select = 1'b0; btn_confirm = 1'b0; btn_quit = 1'b0;
        game_finished = 3'b000; game_points = 24'h0;
        tick(2);
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick(2);

        // Selection wrap
        for (int i = 0; i < 4; i++) begin
            press_select();
            chk("wrap.selected", 32'(selected), 32'(wrap_exp[i]));
            chk("wrap.menu_active", 32'(menu_active), 32'd1);
            chk("wrap.start", 32'(game_start), 32'd0);
        end
        press_select();
        chk("wrap.sel2", 32'(selected), 32'd2);

        // Launch and grant of game 2
        btn_confirm = 1'b1; tick(1);
        chk("launch.state", 32'(state), 32'd1);
        chk("launch.start", 32'(game_start), 32'b100);
        chk("launch.active", 32'(game_active), 32'b100);
        btn_confirm = 1'b0; tick(1);
        chk("run.state", 32'(state), 32'd2);
        chk("run.start", 32'(game_start), 32'd0);
        chk("run.active", 32'(game_active), 32'b100);

        // Record update with 45, then an 8-cycle result hold
        game_points = {8'd45, 8'd0, 8'd0};
        game_finished = 3'b100; tick(1);
        game_finished = 3'b000;
        chk("rec.state", 32'(state), 32'd3);
        chk("rec.last", 32'(last_points), 32'd45);
        chk("rec.newrec", 32'(new_record), 32'd1);
        chk("rec.high", 32'(high_score), 32'd45);
        tick(7);
        chk("hold.state7", 32'(state), 32'd3);
        tick(1);
        chk("hold.state8", 32'(state), 32'd0);
        chk("hold.newrec", 32'(new_record), 32'd0);
        chk("hold.last", 32'(last_points), 32'd45);

        // Equal score is not a record; leave result early on confirm
        launch();
        game_finished = 3'b100; tick(1);
        game_finished = 3'b000;
        chk("eq.newrec", 32'(new_record), 32'd0);
        chk("eq.high", 32'(high_score), 32'd45);
        btn_confirm = 1'b1; tick(1);
        chk("early.state", 32'(state), 32'd0);
        btn_confirm = 1'b0; tick(1);

        // Finished and quit together
        launch();
        game_points = {8'd30, 8'd0, 8'd0};
        game_finished = 3'b100; btn_quit = 1'b1; tick(1);
        game_finished = 3'b000; btn_quit = 1'b0;
        chk("fq.state", 32'(state), 32'd3);
        chk("fq.clear", 32'(game_clear), 32'd0);
        chk("fq.last", 32'(last_points), 32'd30);
        chk("fq.high", 32'(high_score), 32'd45);
        tick(1);
        btn_confirm = 1'b1; tick(1);
        btn_confirm = 1'b0; tick(1);

        // Select and confirm together
        btn_select = 1'b1; btn_confirm = 1'b1; tick(1);
        chk("sc.state", 32'(state), 32'd1);
        chk("sc.selected", 32'(selected), 32'd2);
        btn_select = 1'b0; btn_confirm = 1'b0; tick(1);

        // Abort via quit
        btn_quit = 1'b1; tick(1);
        chk("abort.state", 32'(state), 32'd4);
        chk("abort.clear", 32'(game_clear), 32'b100);
        chk("abort.active", 32'(game_active), 32'd0);
        btn_quit = 1'b0; tick(1);
        chk("abort.menu", 32'(state), 32'd0);
        chk("abort.clear0", 32'(game_clear), 32'd0);
        chk("abort.high", 32'(high_score), 32'd45);

        // Finish from a non-selected core is ignored
        press_select();
        press_select();
        chk("ns.selected", 32'(selected), 32'd1);
        launch();
        chk("ns.active", 32'(game_active), 32'b010);
        game_points = {8'd0, 8'd10, 8'd99};
        game_finished = 3'b001; tick(3);
        chk("ns.state", 32'(state), 32'd2);
        chk("ns.last", 32'(last_points), 32'd30);
        game_finished = 3'b011; tick(1);
        game_finished = 3'b000;
        chk("g1.state", 32'(state), 32'd3);
        chk("g1.last", 32'(last_points), 32'd10);
        chk("g1.newrec", 32'(new_record), 32'd1);
        chk("g1.high", 32'(high_score), 32'd10);

        // Asynchronous reset in RESULT, confirm held through release
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("arst");
        btn_confirm = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("held.state", 32'(state), 32'd0);
        chk("held.start", 32'(game_start), 32'd0);
        btn_confirm = 1'b0; tick(1);
        press_select();
        press_select();
        chk("scorerst.sel", 32'(selected), 32'd2);
        chk("scorerst.high", 32'(high_score), 32'd0);

`ifdef MENU_AUTOCYCLE_EN
        tick(8);
        press_select();
        chk("auto.sel0", 32'(selected), 32'd0);
        tick(14);
        chk("auto.hold", 32'(selected), 32'd0);
        tick(1);
        chk("auto.adv", 32'(selected), 32'd1);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_session_scheduler.md
Name: game_session_scheduler

Overview:
- Top-level session controller for the arcade: shares one set of player buttons and the display path among NUM_GAMES game cores.
- Runs the menu, starts the chosen core, grants it the shared I/O and monitors its finished flag.
- Records the per-game high score, holds a result screen, then returns to the menu.
- Sits above the per-game control units; drives their start and clear inputs.

Parameters:
- NUM_GAMES, 4, number of game cores sharing the I/O (2..8).
- PW, 8, width of each game's points bus and of every score register.
- RESULT_CYCLES, 150000000, result-screen hold time in clock cycles (3 s at 50 MHz).
- IDLE_CYCLES, 500000000, menu inactivity before auto-cycling (optional feature only).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- btn_select  in  1  debounced level: advance menu selection.
- btn_confirm  in  1  debounced level: launch the game, or leave the result screen early.
- btn_quit  in  1  debounced level: abort the running game.
- game_finished  in  NUM_GAMES  per-core finished flag (level).
- game_points  in  NUM_GAMES*PW  per-core points, game i at bits [i*PW +: PW].
- game_start  out  NUM_GAMES  one-hot, one-cycle start pulse.
- game_clear  out  NUM_GAMES  one-hot, one-cycle clear pulse to the core's reset.
- game_active  out  NUM_GAMES  one-hot grant of the shared buttons and display.
- selected  out  $clog2(NUM_GAMES)  current menu selection.
- menu_active  out  1  high in MENU.
- last_points  out  PW  points captured at the last finish.
- high_score  out  PW  stored high score of the currently selected game.
- new_record  out  1  high during RESULT if last_points beat the stored record.
- state  out  3  current state encoding.

Behaviour:
- Button inputs: each is rising-edge detected (registered previous value). The previous-value registers reset to 1, so a button held through reset does not produce an edge.
- Reset values:
  - state = MENU (0), selected = 0, menu_active = 1.
  - All high scores = 0, last_points = 0, new_record = 0.
  - game_start, game_clear and game_active all 0; result counter = 0.
- State encodings: MENU = 0, LAUNCH = 1, RUNNING = 2, RESULT = 3, ABORT = 4. Any unused encoding returns to MENU on the next clock.
- MENU:
  - A select edge sets selected to selected+1, wrapping from NUM_GAMES-1 to 0.
  - A confirm edge moves to LAUNCH.
  - Select and confirm in the same cycle: confirm wins and selected is unchanged.
  - A quit edge is ignored.
- LAUNCH (1 cycle): game_start[selected] = 1, then RUNNING. Latency from the confirm edge-detect cycle to the start pulse is 1 clock.
- RUNNING:
  - If game_finished[selected]: capture points into last_points. If points > high_score[selected] (strictly greater), update the high score and set new_record. Clear the result counter and go to RESULT.
  - Else, on a quit edge, go to ABORT.
  - finished and quit in the same cycle: finished wins.
  - finished flags from non-selected cores are ignored.
  - select and confirm edges are ignored.
- RESULT:
  - The counter increments each cycle.
  - Leave for MENU when count == RESULT_CYCLES-1 or on a confirm edge, whichever comes first.
  - new_record clears on exit; last_points is retained.
  - Select and quit edges are ignored.
- ABORT (1 cycle): game_clear[selected] = 1, no score update, then MENU.
- game_active[selected] = 1 in LAUNCH, RUNNING and RESULT; 0 in MENU and ABORT. selected is frozen outside MENU.
- high_score is a combinational mux of the registered score array indexed by selected.
- Reset mid-game: all registers, including the high scores, return to their reset values immediately.

Optional Feature:
- Macro: MENU_AUTOCYCLE_EN.
- Defined: in MENU, an idle counter increments every cycle and clears on any button edge or on leaving MENU. At IDLE_CYCLES-1, selected advances with the same wrap rule and the counter clears. This gives an attract-mode preview.
- Undefined: no idle counter; selected changes only on a select edge.

Decomposition:
- Shared package game_pkg:
  - State encodings.
  - Width helper SEL_W = $clog2(NUM_GAMES).
  - Default PW.
- Sub-module button_edge: one rising-edge detector, previous-value register reset to 1. Instantiated three times.
- The FSM, counters and score array stay in the top module.

Test Plan:
- Parameter overrides for all tests: NUM_GAMES=3, RESULT_CYCLES=8, IDLE_CYCLES=16.
- Selection wrap: 4 select edges from reset -> selected 1,2,0,1; menu_active stays 1; game_start stays 0.
- Launch and grant: selected=2, confirm edge -> next cycle game_start=3'b100 for one cycle; game_active=3'b100; state=1 then 2.
- Record update: finish game 2 with points=45 (record 0) -> last_points=45, new_record=1, high_score=45; returns to MENU after 8 cycles with new_record=0. A second run with 45 -> new_record=0 (strict compare).
- Simultaneous events:
  - finished and quit in the same cycle -> RESULT, no game_clear.
  - select and confirm in the same MENU cycle -> LAUNCH with selected unchanged.
  - finished asserted on non-selected game 0 while running game 1 -> no transition.
- Abort and reset:
  - quit edge while RUNNING -> game_clear[selected] for one cycle, high score unchanged, MENU.
  - btn_confirm held high through reset release -> no launch.
  - async reset in RESULT -> all outputs at reset values with no clock edge.
- With MENU_AUTOCYCLE_EN defined: 16 idle cycles -> selected increments; a select edge at cycle 10 restarts the idle count.
